// File: rtl/lcd_nibble_reader.sv
// lcd_nibble_reader: HD44780-style 4-bit read cycle engine.
// One request performs a full read: RW=1, two E pulses (upper nibble first),
// and the two sampled nibbles are reassembled into a byte on DATA.
// Status reads (RS=0) also update BF/ADDR.
//
// Optional feature macro: LCD_BF_WAIT_EN
//   When defined, a status request re-polls until the busy flag reads 0 or
//   MAX_POLLS reads have been made (then TIMEOUT pulses with VALID).
//   When undefined, TIMEOUT is tied low and no poll counter is built.
//
// Ports:
//   clk_i       system clock (50 MHz nominal)
//   rst_i       synchronous reset, active-high
//   req_i       start a read; accepted only while ready_o=1
//   rs_sel_i    0 = status read, 1 = data read; captured on accept
//   sf_d_in_i   LCD data bus input (SF_D[11:8])
//   lcd_e_o     enable strobe
//   lcd_rs_o    register select
//   lcd_rw_o    1 = LCD drives the bus (tristate control for the top level)
//   ready_o     idle, able to accept a request
//   valid_o     one-cycle pulse, data_o valid
//   data_o      assembled byte {upper, lower}; holds until the next valid_o
//   bf_o        busy flag from the last status read
//   addr_o      address counter from the last status read
//   timeout_o   busy-flag poll limit hit (LCD_BF_WAIT_EN only)

module lcd_nibble_reader #(
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_EHIGH   = 12,
  parameter int unsigned T_GAP     = 50,
  parameter int unsigned T_HOLD    = 2
`ifdef LCD_BF_WAIT_EN
  ,
  parameter int unsigned MAX_POLLS = 1000
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic       rs_sel_i,
  input  logic [3:0] sf_d_in_i,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       ready_o,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       bf_o,
  output logic [6:0] addr_o,
  output logic       timeout_o
);

  // Counter sized for the longest state duration.
  localparam int unsigned T_MAX_A = (T_SETUP > T_EHIGH) ? T_SETUP : T_EHIGH;
  localparam int unsigned T_MAX_B = (T_GAP > T_HOLD) ? T_GAP : T_HOLD;
  localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] CNT_EHIGH = CNT_W'(T_EHIGH - 1);
  localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_HOLD  = CNT_W'(T_HOLD - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_UPPER_HI = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_LOWER_HI = 3'd4;
  localparam logic [2:0] S_HOLD     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
`ifdef LCD_BF_WAIT_EN
  localparam logic [2:0] S_POLL     = 3'd7;

  localparam int unsigned POLL_W = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS - 1);
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic             rw_q, rw_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             bf_q, bf_d;
  logic [6:0]       addr_q, addr_d;
  logic [3:0]       upper_q, upper_d;
  logic [3:0]       lower_q, lower_d;
  logic             cnt_zero_c;
`ifdef LCD_BF_WAIT_EN
  logic [POLL_W-1:0] poll_q, poll_d;
  logic              timeout_q, timeout_d;
`endif

  assign cnt_zero_c = (cnt_q == '0);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    ready_d = ready_q;
    valid_d = 1'b0;
    data_d  = data_q;
    bf_d    = bf_q;
    addr_d  = addr_q;
    upper_d = upper_q;
    lower_d = lower_q;
`ifdef LCD_BF_WAIT_EN
    poll_d    = poll_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_i && ready_q) begin
          rs_d    = rs_sel_i;
          rw_d    = 1'b1;
          ready_d = 1'b0;
          cnt_d   = CNT_SETUP;
          state_d = S_SETUP;
`ifdef LCD_BF_WAIT_EN
          poll_d  = '0;
`endif
        end
      end

      S_SETUP: begin
        if (cnt_zero_c) begin
          e_d     = 1'b1;
          cnt_d   = CNT_EHIGH;
          state_d = S_UPPER_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // Nibble is sampled once, on the last E-high cycle.
      S_UPPER_HI: begin
        if (cnt_zero_c) begin
          upper_d = sf_d_in_i;
          e_d     = 1'b0;
          cnt_d   = CNT_GAP;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_zero_c) begin
          e_d     = 1'b1;
          cnt_d   = CNT_EHIGH;
          state_d = S_LOWER_HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_LOWER_HI: begin
        if (cnt_zero_c) begin
          lower_d = sf_d_in_i;
          e_d     = 1'b0;
          cnt_d   = CNT_HOLD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // RW/RS held; at the end either publish the byte or re-poll.
      S_HOLD: begin
        if (cnt_zero_c) begin
`ifdef LCD_BF_WAIT_EN
          if (!rs_q && upper_q[3] && (poll_q != POLL_LAST)) begin
            poll_d  = poll_q + 1'b1;
            cnt_d   = CNT_GAP;
            state_d = S_POLL;
          end else begin
            timeout_d = !rs_q && upper_q[3];
            valid_d   = 1'b1;
            data_d    = {upper_q, lower_q};
            bf_d      = rs_q ? bf_q : upper_q[3];
            addr_d    = rs_q ? addr_q : {upper_q[2:0], lower_q};
            state_d   = S_DONE;
          end
`else
          valid_d = 1'b1;
          data_d  = {upper_q, lower_q};
          bf_d    = rs_q ? bf_q : upper_q[3];
          addr_d  = rs_q ? addr_q : {upper_q[2:0], lower_q};
          state_d = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

`ifdef LCD_BF_WAIT_EN
      // E low, RW still 1, between busy-flag polls.
      S_POLL: begin
        if (cnt_zero_c) begin
          cnt_d   = CNT_SETUP;
          state_d = S_SETUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif

      // Release the bus; E is already low so RW may change here.
      S_DONE: begin
        rw_d    = 1'b0;
        rs_d    = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        e_d     = 1'b0;
        rw_d    = 1'b0;
        rs_d    = 1'b0;
        ready_d = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      bf_q    <= 1'b0;
      addr_q  <= '0;
      upper_q <= '0;
      lower_q <= '0;
`ifdef LCD_BF_WAIT_EN
      poll_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      bf_q    <= bf_d;
      addr_q  <= addr_d;
      upper_q <= upper_d;
      lower_q <= lower_d;
`ifdef LCD_BF_WAIT_EN
      poll_q    <= poll_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign lcd_e_o  = e_q;
  assign lcd_rs_o = rs_q;
  assign lcd_rw_o = rw_q;
  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign bf_o     = bf_q;
  assign addr_o   = addr_q;
`ifdef LCD_BF_WAIT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_nibble_reader.sv
// Bench for lcd_nibble_reader (default build, LCD_BF_WAIT_EN undefined).
// The reference describes a read as a timeline of cycle offsets from accept.
module tb_lcd_nibble_reader;

  localparam int TS  = 2;
  localparam int TE  = 12;
  localparam int TG  = 50;
  localparam int TH  = 2;
  localparam int LAT = TS + 2*TE + TG + TH + 1;

  logic       clk, rst, req, rs_sel;
  logic [3:0] sf_d;
  logic       lcd_e_o, lcd_rs_o, lcd_rw_o, ready_o, valid_o, bf_o, timeout_o;
  logic [7:0] data_o;
  logic [6:0] addr_o;

  lcd_nibble_reader dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .rs_sel_i (rs_sel),
    .sf_d_in_i(sf_d),
    .lcd_e_o  (lcd_e_o),
    .lcd_rs_o (lcd_rs_o),
    .lcd_rw_o (lcd_rw_o),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .bf_o     (bf_o),
    .addr_o   (addr_o),
    .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference state: k = cycles since accept (0 = idle).
  int         k = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         last_valid = -1;
  bit         pin_lat = 0;
  bit         spacing_on = 0;
  logic       m_rs = 0;
  logic [7:0] cur = 0;
  logic [7:0] m_data = 0;
  logic       m_bf = 0;
  logic [6:0] m_addr = 0;
  logic [7:0] byte_q[$];
  logic       prev_e = 0, prev_rw = 0, prev_rs = 0;

  function automatic bit e_upper(input int kk);
    return kk >= TS + 1 && kk <= TS + TE;
  endfunction
  function automatic bit e_lower(input int kk);
    return kk >= TS + TE + TG + 1 && kk <= TS + 2*TE + TG;
  endfunction

  // Advance the reference on the edge just taken, act as the LCD, compare.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      k = 0; m_data = 0; m_bf = 0; m_addr = 0; m_rs = 0;
    end else if (k == 0) begin
      if (req) begin
        k = 1;
        m_rs = rs_sel;
        cur = (byte_q.size() > 0) ? byte_q.pop_front() : 8'($urandom);
        acc_cyc = cyc - 1;
      end
    end else if (k == LAT) begin
      k = 0;
    end else begin
      k++;
      if (k == LAT) begin
        m_data = cur;
        if (!m_rs) begin
          m_bf = cur[7];
          m_addr = cur[6:0];
        end
      end
    end

    chk("lcd_e",   32'(lcd_e_o),  32'(e_upper(k) || e_lower(k)));
    chk("lcd_rw",  32'(lcd_rw_o), 32'(k != 0));
    chk("lcd_rs",  32'(lcd_rs_o), 32'((k != 0) ? m_rs : 1'b0));
    chk("ready",   32'(ready_o),  32'(k == 0));
    chk("valid",   32'(valid_o),  32'(k == LAT));
    chk("data",    32'(data_o),   32'(m_data));
    chk("bf",      32'(bf_o),     32'(m_bf));
    chk("addr",    32'(addr_o),   32'(m_addr));
    chk("timeout", 32'(timeout_o), 32'(0));

    // Bus-turnaround protocol
    if (lcd_e_o && prev_e) begin
      chk("rw_stable_e", 32'(lcd_rw_o), 32'(prev_rw));
      chk("rs_stable_e", 32'(lcd_rs_o), 32'(prev_rs));
    end
    if (ready_o) chk("e_low_idle", 32'(lcd_e_o), 32'(0));

    if (valid_o && pin_lat) begin
      chk("latency", 32'(cyc - acc_cyc), 32'(79));
      pin_lat = 0;
    end
    if (valid_o && spacing_on) begin
      if (last_valid >= 0) chk("valid_spacing", 32'(cyc - last_valid), 32'(80));
      last_valid = cyc;
    end
    prev_e = lcd_e_o; prev_rw = lcd_rw_o; prev_rs = lcd_rs_o;

    // LCD drives the addressed nibble while E is high, junk otherwise
    if (e_upper(k))      sf_d = cur[7:4];
    else if (e_lower(k)) sf_d = cur[3:0];
    else                 sf_d = 4'($urandom);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!valid_o && n < 200) begin step(); n++; end
    if (!valid_o) chk({nm, "_valid_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 200) begin step(); n++; end
    if (!ready_o) chk("ready_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    int nv;
    rst = 1; req = 0; rs_sel = 0; sf_d = 0;
    repeat (3) step();
    chk("rst_e",     32'(lcd_e_o),  32'(0));
    chk("rst_rw",    32'(lcd_rw_o), 32'(0));
    chk("rst_ready", 32'(ready_o),  32'(1));
    chk("rst_data",  32'(data_o),   32'(0));
    rst = 0;
    step();

    // Status read 0x4A
    byte_q.push_back(8'h4A);
    pin_lat = 1; rs_sel = 0; req = 1;
    step();
    req = 0;
    wait_valid("t1");
    chk("t1_data", 32'(data_o), 32'h4A);
    chk("t1_bf",   32'(bf_o),   32'(0));
    chk("t1_addr", 32'(addr_o), 32'h4A);
    wait_ready();

    // Data read 0xB7: BF/ADDR keep the status values
    byte_q.push_back(8'hB7);
    rs_sel = 1; req = 1;
    step();
    req = 0;
    wait_valid("t2");
    chk("t2_data", 32'(data_o),   32'hB7);
    chk("t2_rs",   32'(lcd_rs_o), 32'(1));
    chk("t2_bf",   32'(bf_o),     32'(0));
    chk("t2_addr", 32'(addr_o),   32'h4A);
    wait_ready();

    // Reset during the inter-nibble gap
    rs_sel = 0; req = 1;
    step();
    req = 0;
    repeat (30) step();
    chk("t3_gap_rw", 32'(lcd_rw_o), 32'(1));
    rst = 1;
    step();
    chk("t3_e",     32'(lcd_e_o),  32'(0));
    chk("t3_rw",    32'(lcd_rw_o), 32'(0));
    chk("t3_ready", 32'(ready_o),  32'(1));
    chk("t3_valid", 32'(valid_o),  32'(0));
    chk("t3_data",  32'(data_o),   32'(0));
    rst = 0;
    step();

    // REQ held high: three back-to-back reads
    last_valid = -1; spacing_on = 1;
    rs_sel = 1'($urandom); req = 1;
    nv = 0;
    for (int i = 0; i < 400 && nv < 3; i++) begin
      step();
      if (valid_o) nv++;
    end
    req = 0;
    spacing_on = 0;
    chk("t4_reads", 32'(nv), 32'(3));
    wait_ready();

    // Random requests, select and occasional reset
    for (int i = 0; i < 3000; i++) begin
      req    = ($urandom_range(3) == 0);
      rs_sel = 1'($urandom);
      rst    = ($urandom_range(699) == 0);
      step();
    end
    req = 0; rst = 0;
    step();
    wait_ready();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
